dmem_lsu: RTL and testbench
===========================

// Module: dmem_lsu
// PURPOSE
//  MEM-stage load/store unit: initiator side of the word-only data memory port.
//  Converts pipeline lb/lh/lw/lbu/lhu/sb/sh/sw requests into word accesses:
//  combinational word read, synchronous word write.
//  Sub-word stores use a 2-cycle read-modify-write and stall the pipeline.
//  Also flags misaligned and out-of-range addresses, and keeps access counters.
// PARAMETERS
//  MEM_WORDS  256  words in data memory; word index = addr[IDX_W+1:2], IDX_W=$clog2(MEM_WORDS)
//  CNT_W      16   width of each performance counter (wraps)
// PORTS
//  clk           in   1      clock
//  reset         in   1      asynchronous, active-high
//  req_load      in   1      load request this cycle
//  req_store     in   1      store request this cycle (load+store together = store wins)
//  req_size      in   2      0=byte 1=half 2=word; 3=illegal, treated as misaligned
//  req_unsigned  in   1      zero-extend sub-word loads (lbu/lhu)
//  req_addr      in   32     byte address
//  req_wdata     in   32     store data; byte/half taken from bits [7:0]/[15:0]
//  stall         out  1      hold the pipeline; request inputs must stay stable while high
//  load_data     out  32     extracted and extended load result (combinational)
//  fault         out  1      sticky: misaligned or out-of-range access seen
//  dm_memread    out  1      to dmem memread
//  dm_memwrite   out  1      to dmem memwrite (dmem writes on posedge clk)
//  dm_addr       out  32     to dmem addr
//  dm_wd         out  32     to dmem wd
//  dm_rd         in   32     from dmem rd (valid in the same cycle as dm_memread)
//  cnt_load      out  CNT_W  completed loads
//  cnt_store     out  CNT_W  completed stores
//  cnt_rmw       out  CNT_W  completed sub-word read-modify-writes
// BEHAVIOUR
//  Reset: state=IDLE; fault, merge register and all counters = 0.
//   All dm_* outputs, stall and load_data = 0 while reset is high.
//  Legality:
//   - misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size=3
//   - out-of-range: addr[31:IDX_W+2]!=0
//   - illegal request: no memread/memwrite, load_data=0, stall=0, fault<=1 next edge.
//   - Illegal requests are not counted.
//  FSM states: IDLE, RMW_WR.
//  IDLE
//   - load: dm_memread=1, dm_addr=req_addr, stall=0.
//     load_data = selected byte/half of dm_rd at addr[1:0], sign- or zero-extended; word passes through.
//     cnt_load++ at the edge.
//   - word store: dm_memwrite=1, dm_wd=req_wdata, stall=0; cnt_store++.
//   - sub-word store: dm_memread=1, stall=1, dm_memwrite=0.
//     At the edge: latch the merged word (dm_rd with the target lane replaced), latch dm_addr, go to RMW_WR.
//   - no request: all dm_* = 0; load_data=0.
//  RMW_WR (exactly 1 cycle)
//   - Outputs: dm_memwrite=1, dm_addr=latched, dm_wd=latched merged word, dm_memread=0.
//   - stall=0 so the pipeline advances at this edge.
//   - At the edge: cnt_store++, cnt_rmw++, return to IDLE.
//   - Request inputs are ignored in this state (they still hold the stalled store).
//  Latency: load/word store 0 extra cycles; sub-word store 1 stall cycle.
//  Lane select: byte lane = addr[1:0], half lane = addr[1]; little-endian.
//  Counters wrap from 2^CNT_W-1 to 0 silently.
//  Reset mid-RMW (asserted in RMW_WR): write suppressed immediately (async), state->IDLE, counters cleared.
//  fault clears only on reset.
// TESTING
//  1. mem[1]=0x11223344. lb addr=0x5 -> load_data=0x00000033. lbu addr=0x7 -> 0x00000011.
//     lh addr=0x6 -> 0x00001122.
//  2. mem[2]=0x000080F0. lb addr=0x8 -> 0xFFFFFFF0. lh addr=0x8 -> 0xFFFF80F0. lhu addr=0x8 -> 0x000080F0.
//  3. mem[3]=0xAABBCCDD, sb addr=0xD wdata=0x77.
//     Cycle 1: stall=1, memread=1. Cycle 2: memwrite=1, wd=0xAABB77DD.
//     Then lw addr=0xC -> 0xAABB77DD, cnt_rmw=1.
//  4. sw addr=0x2 -> no memwrite, fault=1 next cycle.
//     lw addr=0x400 (MEM_WORDS=256) -> no memread, fault stays 1, cnt_load unchanged.
//  5. sh addr=0x10 then assert reset during RMW_WR -> no memwrite that cycle.
//     State IDLE, all counters 0, mem[4] unchanged.
//  6. CNT_W=4: 16 back-to-back lw -> cnt_load wraps to 0.
//     Also load+store asserted together -> treated as store, cnt_load unchanged.

Source files
------------

// File: rtl/dmem_lsu_if.sv
// Word-only data memory port between the MEM-stage load/store unit (master)
// and the data memory (slave). Memory reads are combinational, writes land on posedge clk.
interface dmem_lsu_if;
  logic        dm_memread;
  logic        dm_memwrite;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic [31:0] dm_rd;

  modport master (
    output dm_memread, dm_memwrite, dm_addr, dm_wd,
    input  dm_rd
  );

  modport slave (
    input  dm_memread, dm_memwrite, dm_addr, dm_wd,
    output dm_rd
  );
endinterface

// File: rtl/dmem_lsu.sv
// MEM-stage load/store unit: turns byte/half/word loads and stores into word
// accesses, with a one-stall read-modify-write for sub-word stores.
module dmem_lsu #(
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              fault,
  dmem_lsu_if.master        dm,
  output logic [CNT_W-1:0]  cnt_load,
  output logic [CNT_W-1:0]  cnt_store,
  output logic [CNT_W-1:0]  cnt_rmw
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t             state_q;
  logic               fault_q;
  logic [31:0]        merge_q;
  logic [31:0]        addr_q;
  logic [CNT_W-1:0]   cnt_load_q, cnt_store_q, cnt_rmw_q;

  logic               misaligned, out_of_range, legal, req_any;
  logic [4:0]         bsh, hsh;
  logic [31:0]        rd_shb, rd_shh, ext, merged;

  assign req_any      = req_load | req_store;
  assign misaligned   = (req_size == 2'd3) ||
                        (req_size == 2'd1 && req_addr[0]) ||
                        (req_size == 2'd2 && req_addr[1:0] != 2'b00);
  assign out_of_range = (req_addr >> (IDX_W + 2)) != '0;
  assign legal        = !misaligned && !out_of_range;

  assign bsh    = {req_addr[1:0], 3'b000};
  assign hsh    = {req_addr[1], 4'b0000};
  assign rd_shb = dm.dm_rd >> bsh;
  assign rd_shh = dm.dm_rd >> hsh;

  always_comb begin
    ext    = dm.dm_rd;
    merged = req_wdata;
    case (req_size)
      2'd0: begin
        ext    = {{24{!req_unsigned & rd_shb[7]}}, rd_shb[7:0]};
        merged = (dm.dm_rd & ~(32'h0000_00FF << bsh)) | ({24'b0, req_wdata[7:0]} << bsh);
      end
      2'd1: begin
        ext    = {{16{!req_unsigned & rd_shh[15]}}, rd_shh[15:0]};
        merged = (dm.dm_rd & ~(32'h0000_FFFF << hsh)) | ({16'b0, req_wdata[15:0]} << hsh);
      end
      default: begin
        ext    = dm.dm_rd;
        merged = req_wdata;
      end
    endcase
  end

  // Outputs are forced low during reset so an in-flight RMW write is dropped immediately.
  always_comb begin
    dm.dm_memread  = 1'b0;
    dm.dm_memwrite = 1'b0;
    dm.dm_addr     = '0;
    dm.dm_wd       = '0;
    stall          = 1'b0;
    load_data      = '0;
    if (!reset) begin
      if (state_q == RMW_WR) begin
        dm.dm_memwrite = 1'b1;
        dm.dm_addr     = addr_q;
        dm.dm_wd       = merge_q;
      end else if (req_any && legal) begin
        dm.dm_addr = req_addr;
        if (req_store) begin
          if (req_size == 2'd2) begin
            dm.dm_memwrite = 1'b1;
            dm.dm_wd       = req_wdata;
          end else begin
            dm.dm_memread = 1'b1;
            stall         = 1'b1;
          end
        end else begin
          dm.dm_memread = 1'b1;
          load_data     = ext;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      fault_q     <= 1'b0;
      merge_q     <= '0;
      addr_q      <= '0;
      cnt_load_q  <= '0;
      cnt_store_q <= '0;
      cnt_rmw_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_any) begin
            if (!legal) begin
              fault_q <= 1'b1;
            end else if (req_store) begin
              if (req_size == 2'd2) begin
                cnt_store_q <= cnt_store_q + CNT_W'(1);
              end else begin
                merge_q <= merged;
                addr_q  <= req_addr;
                state_q <= RMW_WR;
              end
            end else begin
              cnt_load_q <= cnt_load_q + CNT_W'(1);
            end
          end
        end
        RMW_WR: begin
          cnt_store_q <= cnt_store_q + CNT_W'(1);
          cnt_rmw_q   <= cnt_rmw_q + CNT_W'(1);
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fault     = fault_q;
  assign cnt_load  = cnt_load_q;
  assign cnt_store = cnt_store_q;
  assign cnt_rmw   = cnt_rmw_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: a byte-level reference memory predicts loads
// and writes; a negedge monitor pops and compares whenever the DUT accesses memory.
module tb_dmem_lsu;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_load, req_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, fault;
  logic [31:0] load_data;
  logic [3:0]  cnt_load, cnt_store, cnt_rmw;

  dmem_lsu_if bus();

  logic [31:0] mem  [256];
  logic [31:0] rmem [256];

  int ntests = 0;
  int nfail  = 0;
  int m_load = 0, m_store = 0, m_rmw = 0;
  bit m_fault = 1'b0;
  logic [31:0] exp_load_q [$];
  logic [63:0] exp_wr_q   [$];

  always #5 clk = ~clk;

  dmem_lsu #(.MEM_WORDS(256), .CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_load     (req_load),
    .req_store    (req_store),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .load_data    (load_data),
    .fault        (fault),
    .dm           (bus),
    .cnt_load     (cnt_load),
    .cnt_store    (cnt_store),
    .cnt_rmw      (cnt_rmw)
  );

  assign bus.dm_rd = mem[bus.dm_addr[9:2]];
  always @(posedge clk) if (bus.dm_memwrite) mem[bus.dm_addr[9:2]] <= bus.dm_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every DUT memory access must match the oldest prediction.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!reset) begin
      if (bus.dm_memread && !stall) begin
        if (exp_load_q.size() == 0) begin
          ntests++; nfail++;
          $display("FAIL unexpected_load: addr %h with no load pending", bus.dm_addr);
        end else begin
          chk("load_data", load_data, exp_load_q.pop_front());
        end
      end else begin
        chk("load_data_idle", load_data, 32'h0);
      end
      if (bus.dm_memwrite) begin
        if (exp_wr_q.size() == 0) begin
          ntests++; nfail++;
          $display("FAIL unexpected_write: addr %h data %h with no write pending", bus.dm_addr, bus.dm_wd);
        end else begin
          e = exp_wr_q.pop_front();
          chk("wr_addr", bus.dm_addr, e[63:32]);
          chk("wr_data", bus.dm_wd, e[31:0]);
        end
      end
    end
  end

  task automatic check_state();
    chk("cnt_load",  {28'b0, cnt_load},  32'(m_load % 16));
    chk("cnt_store", {28'b0, cnt_store}, 32'(m_store % 16));
    chk("cnt_rmw",   {28'b0, cnt_rmw},   32'(m_rmw % 16));
    chk("fault",     {31'b0, fault},     {31'b0, m_fault});
    chk("pending",   32'(exp_load_q.size() + exp_wr_q.size()), 32'h0);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    check_state();
    req_load = 0; req_store = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
  endtask

  task automatic do_op(input bit ld, input bit st, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input bit use_k = 1'b0, input logic [31:0] k = 32'h0);
    logic [7:0]  b [4];
    logic [31:0] w, ev;
    int          off, v;
    bit          legal, rmw;
    @(posedge clk); #1;
    check_state();
    req_load = ld; req_store = st; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    legal = !(sz == 3 || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 0)) && (a < 32'd1024);
    rmw = 1'b0;
    off = int'(a[1:0]);
    w = rmem[a[9:2]];
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    if (ld || st) begin
      if (!legal) begin
        m_fault = 1'b1;
      end else if (st) begin
        if (sz == 0) b[off] = wd[7:0];
        else if (sz == 1) begin b[off] = wd[7:0]; b[off+1] = wd[15:8]; end
        else for (int i = 0; i < 4; i++) b[i] = wd[8*i +: 8];
        w = {b[3], b[2], b[1], b[0]};
        exp_wr_q.push_back({a, w});
        rmem[a[9:2]] = w;
        m_store++;
        if (sz != 2) begin m_rmw++; rmw = 1'b1; end
      end else begin
        if (sz == 2) ev = w;
        else if (sz == 0) begin
          v = int'(b[off]);
          if (!uns && v > 127) v = v - 256;
          ev = 32'(v);
        end else begin
          v = int'(b[off]) + 256 * int'(b[off+1]);
          if (!uns && v > 32767) v = v - 65536;
          ev = 32'(v);
        end
        exp_load_q.push_back(use_k ? k : ev);
        m_load++;
      end
    end
    @(negedge clk);
    chk("stall", {31'b0, stall}, {31'b0, rmw});
    if (rmw) begin
      @(posedge clk); #1;
      chk("stall_rmw", {31'b0, stall}, 32'h0);
    end
  endtask

  initial begin
    logic [31:0] a, d;
    int          r;
    for (int i = 0; i < 256; i++) begin
      d = $urandom;
      mem[i] = d; rmem[i] = d;
    end
    mem[1] = 32'h1122_3344; rmem[1] = 32'h1122_3344;
    mem[2] = 32'h0000_80F0; rmem[2] = 32'h0000_80F0;
    mem[3] = 32'hAABB_CCDD; rmem[3] = 32'hAABB_CCDD;

    // Reset: outputs must be low even with a legal load presented.
    reset = 1; req_load = 1; req_store = 0; req_size = 2; req_unsigned = 0;
    req_addr = 32'h4; req_wdata = 0;
    #12;
    chk("rst_stall",     {31'b0, stall},           32'h0);
    chk("rst_load_data", load_data,                32'h0);
    chk("rst_memread",   {31'b0, bus.dm_memread},  32'h0);
    chk("rst_memwrite",  {31'b0, bus.dm_memwrite}, 32'h0);
    chk("rst_addr",      bus.dm_addr,              32'h0);
    chk("rst_wd",        bus.dm_wd,                32'h0);
    check_state();
    req_load = 0;
    @(negedge clk); reset = 0;

    do_op(1, 0, 0, 0, 32'h5, 0, 1, 32'h0000_0033);
    do_op(1, 0, 0, 1, 32'h7, 0, 1, 32'h0000_0011);
    do_op(1, 0, 1, 0, 32'h6, 0, 1, 32'h0000_1122);
    do_op(1, 0, 0, 0, 32'h8, 0, 1, 32'hFFFF_FFF0);
    do_op(1, 0, 1, 0, 32'h8, 0, 1, 32'hFFFF_80F0);
    do_op(1, 0, 1, 1, 32'h8, 0, 1, 32'h0000_80F0);
    do_op(0, 1, 0, 0, 32'hD, 32'h0000_0077);
    do_op(1, 0, 2, 0, 32'hC, 0, 1, 32'hAABB_77DD);
    idle();
    chk("cnt_rmw_one", {28'b0, cnt_rmw}, 32'h1);
    do_op(0, 1, 2, 0, 32'h2, 32'hDEAD_BEEF);
    do_op(1, 0, 2, 0, 32'h400, 0);
    idle();
    chk("fault_sticky", {31'b0, fault}, 32'h1);

    // Reset during RMW_WR: the write must vanish at once and state must clear.
    @(posedge clk); #1;
    check_state();
    req_load = 0; req_store = 1; req_size = 1; req_unsigned = 0;
    req_addr = 32'h10; req_wdata = 32'h0000_5A5A;
    @(negedge clk);
    chk("rmw_rst_stall", {31'b0, stall}, 32'h1);
    @(posedge clk); #2;
    reset = 1; #1;
    chk("rmw_rst_memwrite", {31'b0, bus.dm_memwrite}, 32'h0);
    chk("rmw_rst_wd",       bus.dm_wd,                32'h0);
    @(posedge clk); #1;
    req_store = 0; req_size = 0; req_addr = 0; req_wdata = 0;
    @(negedge clk); reset = 0;
    m_load = 0; m_store = 0; m_rmw = 0; m_fault = 1'b0;
    chk("rmw_rst_mem4", mem[4], rmem[4]);

    for (int i = 0; i < 16; i++) do_op(1, 0, 2, 0, {22'b0, 8'($urandom), 2'b00}, 0);
    idle();
    chk("cnt_load_wrap", {28'b0, cnt_load}, 32'h0);
    do_op(1, 1, 2, 0, 32'h20, 32'h1234_5678);
    idle();
    chk("ldst_is_store", {28'b0, cnt_load}, 32'h0);

    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 9));
      a = (r == 0) ? $urandom : 32'($urandom_range(0, 1023));
      r = int'($urandom_range(0, 2));
      do_op(r != 1, r != 0, 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom);
      if ($urandom_range(0, 7) == 0) idle();
    end
    idle();
    idle();
    chk("final_pending", 32'(exp_load_q.size() + exp_wr_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
